// File: rtl/noc_axi4_bridge_read_resp_if.sv
// AXI4 read-channel (AR/R) and line-read memory port bundle for the read-response bridge.
// The bridge takes the slave view; the requester/backing-store side takes the master view.
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH  512
`endif
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH    6
`endif
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH  64
`endif
`ifndef AXI4_LEN_WIDTH
`define AXI4_LEN_WIDTH   8
`endif
`ifndef AXI4_SIZE_WIDTH
`define AXI4_SIZE_WIDTH  3
`endif
`ifndef AXI4_BURST_WIDTH
`define AXI4_BURST_WIDTH 2
`endif
`ifndef AXI4_RESP_WIDTH
`define AXI4_RESP_WIDTH  2
`endif
`ifndef AXI4_USER_WIDTH
`define AXI4_USER_WIDTH  11
`endif

interface noc_axi4_bridge_read_resp_if #(
   parameter int DAT_W = `AXI4_DATA_WIDTH
);
   logic [`AXI4_ID_WIDTH-1:0]    s_axi_arid;
   logic [`AXI4_ADDR_WIDTH-1:0]  s_axi_araddr;
   logic [`AXI4_LEN_WIDTH-1:0]   s_axi_arlen;
   logic [`AXI4_SIZE_WIDTH-1:0]  s_axi_arsize;
   logic [`AXI4_BURST_WIDTH-1:0] s_axi_arburst;
   logic                         s_axi_arvalid;
   logic                         s_axi_arready;

   logic [`AXI4_ID_WIDTH-1:0]    s_axi_rid;
   logic [DAT_W-1:0]             s_axi_rdata;
   logic [`AXI4_RESP_WIDTH-1:0]  s_axi_rresp;
   logic                         s_axi_rlast;
   logic [`AXI4_USER_WIDTH-1:0]  s_axi_ruser;
   logic                         s_axi_rvalid;
   logic                         s_axi_rready;

   logic                         mem_req_val;
   logic [`AXI4_ADDR_WIDTH-1:0]  mem_req_addr;
   logic                         mem_req_rdy;
   logic                         mem_resp_val;
   logic [`AXI4_DATA_WIDTH-1:0]  mem_resp_data;
   logic                         mem_resp_rdy;

   modport slave (
      input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
      output s_axi_arready,
      output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_ruser, s_axi_rvalid,
      input  s_axi_rready,
      output mem_req_val, mem_req_addr,
      input  mem_req_rdy,
      input  mem_resp_val, mem_resp_data,
      output mem_resp_rdy
   );

   modport master (
      output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
      input  s_axi_arready,
      input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_ruser, s_axi_rvalid,
      output s_axi_rready,
      input  mem_req_val, mem_req_addr,
      output mem_req_rdy,
      output mem_resp_val, mem_resp_data,
      input  mem_resp_rdy
   );
endinterface

// File: rtl/noc_axi4_bridge_read_resp.sv
// AXI4 read bridge: one burst in flight, fetches one 64-byte line from the backing store and
// returns it as R beats; bursts that are not INCR, too wide, or leave the line get SLVERR beats.
//
//   state    | meaning
//   IDLE     | arready high, stale memory responses drained
//   MEM_REQ  | line-read request presented to the backing store
//   MEM_WAIT | waiting for the line, mem_resp_rdy high
//   SEND     | returning beats sliced from the captured line, OKAY
//   ERR_SEND | returning arlen+1 SLVERR beats with zero data, no memory access
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH  512
`endif
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH    6
`endif
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH  64
`endif
`ifndef AXI4_LEN_WIDTH
`define AXI4_LEN_WIDTH   8
`endif
`ifndef AXI4_SIZE_WIDTH
`define AXI4_SIZE_WIDTH  3
`endif
`ifndef AXI4_BURST_WIDTH
`define AXI4_BURST_WIDTH 2
`endif
`ifndef AXI4_RESP_WIDTH
`define AXI4_RESP_WIDTH  2
`endif
`ifndef AXI4_USER_WIDTH
`define AXI4_USER_WIDTH  11
`endif

module noc_axi4_bridge_read_resp #(
   parameter int AXI4_DAT_WIDTH_USED = `AXI4_DATA_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst,
   noc_axi4_bridge_read_resp_if.slave     bus
);
   localparam int DAT_W  = AXI4_DAT_WIDTH_USED;
   localparam int LINE_W = `AXI4_DATA_WIDTH;
   localparam int ID_W   = `AXI4_ID_WIDTH;
   localparam int ADDR_W = `AXI4_ADDR_WIDTH;
   localparam int LEN_W  = `AXI4_LEN_WIDTH;
   localparam int SIZE_W = `AXI4_SIZE_WIDTH;
   localparam int RESP_W = `AXI4_RESP_WIDTH;

   localparam logic [SIZE_W-1:0]       MAX_SIZE   = SIZE_W'($clog2(DAT_W/8));
   localparam logic [5:0]              LANE_MASK  = ~6'(DAT_W/8 - 1);
   localparam logic [`AXI4_BURST_WIDTH-1:0] BURST_INCR = 'd1;
   localparam logic [RESP_W-1:0]       RESP_OKAY  = 2'b00;
   localparam logic [RESP_W-1:0]       RESP_SLV   = 2'b10;

   typedef enum logic [2:0] {IDLE, MEM_REQ, MEM_WAIT, SEND, ERR_SEND} state_t;

   state_t              state;
   logic [ID_W-1:0]     ar_id;
   logic [ADDR_W-1:0]   ar_addr;
   logic [LEN_W-1:0]    ar_len;
   logic [SIZE_W-1:0]   ar_size;
   logic [LEN_W-1:0]    beat_cnt;
   logic [LINE_W-1:0]   line_buf;

   logic                arready_q, rvalid_q, rlast_q;
   logic [RESP_W-1:0]   rresp_q;
   logic [ID_W-1:0]     rid_q;
   logic [DAT_W-1:0]    rdata_q;
   logic                mem_req_val_q, mem_resp_rdy_q;
   logic [ADDR_W-1:0]   mem_req_addr_q;

   logic                ar_legal;
   logic [16:0]         ar_span;
   logic [16:0]         ar_end_off;
   logic [LEN_W-1:0]    cnt_nxt;
   logic [ADDR_W-1:0]   beat_addr_nxt;

   // The slice holding a byte is found by aligning its line offset down to the R width.
   function automatic logic [DAT_W-1:0] line_slice(input logic [LINE_W-1:0] line,
                                                   input logic [5:0] off);
      return DAT_W'(line >> {off & LANE_MASK, 3'b000});
   endfunction

   always_comb begin
      ar_span    = '0;
      ar_end_off = '0;
      ar_legal   = 1'b0;
      ar_span    = (17'(bus.s_axi_arlen) + 17'd1) << bus.s_axi_arsize;
      ar_end_off = 17'(bus.s_axi_araddr[5:0]) + ar_span;
      ar_legal   = (bus.s_axi_arburst == BURST_INCR) && (bus.s_axi_arsize <= MAX_SIZE) &&
                   (ar_end_off <= 17'd64);
   end

   always_comb begin
      cnt_nxt       = '0;
      beat_addr_nxt = '0;
      cnt_nxt       = beat_cnt + LEN_W'(1);
      beat_addr_nxt = ar_addr + (ADDR_W'(cnt_nxt) << ar_size);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         ar_id          <= '0;
         ar_addr        <= '0;
         ar_len         <= '0;
         ar_size        <= '0;
         beat_cnt       <= '0;
         line_buf       <= '0;
         arready_q      <= 1'b1;
         rvalid_q       <= 1'b0;
         rlast_q        <= 1'b0;
         rresp_q        <= '0;
         rid_q          <= '0;
         rdata_q        <= '0;
         mem_req_val_q  <= 1'b0;
         mem_req_addr_q <= '0;
         mem_resp_rdy_q <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (bus.s_axi_arvalid) begin
                  ar_id          <= bus.s_axi_arid;
                  ar_addr        <= bus.s_axi_araddr;
                  ar_len         <= bus.s_axi_arlen;
                  ar_size        <= bus.s_axi_arsize;
                  beat_cnt       <= '0;
                  rid_q          <= bus.s_axi_arid;
                  arready_q      <= 1'b0;
                  mem_resp_rdy_q <= 1'b0;
                  if (ar_legal) begin
                     state          <= MEM_REQ;
                     mem_req_val_q  <= 1'b1;
                     mem_req_addr_q <= {bus.s_axi_araddr[ADDR_W-1:6], 6'b000000};
                  end else begin
                     state    <= ERR_SEND;
                     rvalid_q <= 1'b1;
                     rresp_q  <= RESP_SLV;
                     rdata_q  <= '0;
                     rlast_q  <= (bus.s_axi_arlen == '0);
                  end
               end
            end
            MEM_REQ: begin
               if (bus.mem_req_rdy) begin
                  state          <= MEM_WAIT;
                  mem_req_val_q  <= 1'b0;
                  mem_resp_rdy_q <= 1'b1;
               end
            end
            MEM_WAIT: begin
               if (bus.mem_resp_val) begin
                  state          <= SEND;
                  line_buf       <= bus.mem_resp_data;
                  mem_resp_rdy_q <= 1'b0;
                  rvalid_q       <= 1'b1;
                  rresp_q        <= RESP_OKAY;
                  rlast_q        <= (ar_len == '0);
                  rdata_q        <= line_slice(bus.mem_resp_data, ar_addr[5:0]);
               end
            end
            SEND, ERR_SEND: begin
               if (bus.s_axi_rready) begin
                  if (rlast_q) begin
                     state          <= IDLE;
                     rvalid_q       <= 1'b0;
                     rlast_q        <= 1'b0;
                     rresp_q        <= RESP_OKAY;
                     arready_q      <= 1'b1;
                     mem_resp_rdy_q <= 1'b1;
                  end else begin
                     beat_cnt <= cnt_nxt;
                     rlast_q  <= (cnt_nxt == ar_len);
                     if (state == SEND)
                        rdata_q <= line_slice(line_buf, beat_addr_nxt[5:0]);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.s_axi_arready = arready_q;
   assign bus.s_axi_rvalid  = rvalid_q;
   assign bus.s_axi_rlast   = rlast_q;
   assign bus.s_axi_rresp   = rresp_q;
   assign bus.s_axi_rid     = rid_q;
   assign bus.s_axi_rdata   = rdata_q;
   assign bus.s_axi_ruser   = '0;
   assign bus.mem_req_val   = mem_req_val_q;
   assign bus.mem_req_addr  = mem_req_addr_q;
   assign bus.mem_resp_rdy  = mem_resp_rdy_q;

endmodule

// File: tb/tb_noc_axi4_bridge_read_resp.sv
// Bench for noc_axi4_bridge_read_resp at a 64-bit R width: directed bursts plus random bursts
// checked against a line-of-words reference model.
module tb_noc_axi4_bridge_read_resp;
   localparam int W = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   noc_axi4_bridge_read_resp_if #(.DAT_W(W)) bus();

   noc_axi4_bridge_read_resp #(.AXI4_DAT_WIDTH_USED(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic saw_req = 1'b0;
   logic [63:0] line_w [8];

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) if (bus.mem_req_val === 1'b1) saw_req = 1'b1;

   // mode: 0 = rready always high, 1 = random rready, 2 = hold rready low 5 cycles at beat 1
   task automatic do_read(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int mode,
                          input int abort_beat);
      logic         legal;
      logic [511:0] line;
      logic [63:0]  a;
      logic [63:0]  exp_data;
      logic         rr;
      int           sz, i, cyc, stall;
      sz    = 1 << size;
      legal = (burst == 2'b01) && (sz <= W/8) && (int'(addr % 64) + (int'(len) + 1) * sz <= 64);
      for (int k = 0; k < 8; k++) begin
         line_w[k] = {$urandom, $urandom};
         line[64*k +: 64] = line_w[k];
      end
      saw_req = 1'b0;

      @(negedge clk);
      bus.s_axi_arid    = id;
      bus.s_axi_araddr  = addr;
      bus.s_axi_arlen   = len;
      bus.s_axi_arsize  = size;
      bus.s_axi_arburst = burst;
      bus.s_axi_arvalid = 1'b1;
      cyc = 0;
      while (bus.s_axi_arready !== 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk("ar_accept_timeout", cyc < 50, 1'b1);
      @(negedge clk);
      bus.s_axi_arvalid = 1'b0;
      chk("mem_req_val_latency", bus.mem_req_val, legal);
      chk("arready_busy", bus.s_axi_arready, 1'b0);

      if (legal) begin
         chk("mem_req_addr", bus.mem_req_addr, {addr[63:6], 6'b000000});
         repeat ($urandom_range(0, 2)) @(negedge clk);
         bus.mem_req_rdy = 1'b1;
         @(negedge clk);
         bus.mem_req_rdy = 1'b0;
         chk("mem_req_val_drop", bus.mem_req_val, 1'b0);
         chk("mem_resp_rdy_wait", bus.mem_resp_rdy, 1'b1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         bus.mem_resp_val  = 1'b1;
         bus.mem_resp_data = line;
         @(negedge clk);
         bus.mem_resp_val  = 1'b0;
         bus.mem_resp_data = {16{$urandom}};
      end

      i = 0; cyc = 0; stall = 0;
      while (i <= int'(len) && cyc < 2000) begin
         a        = addr + 64'(i * sz);
         exp_data = legal ? line_w[a[5:3]] : 64'h0;
         chk("rvalid", bus.s_axi_rvalid, 1'b1);
         chk("rdata", bus.s_axi_rdata, exp_data);
         chk("rlast", bus.s_axi_rlast, i == int'(len));
         chk("rresp", bus.s_axi_rresp, legal ? 2'b00 : 2'b10);
         chk("rid", bus.s_axi_rid, id);
         chk("ruser", bus.s_axi_ruser, 0);
         if (abort_beat == i) begin
            bus.s_axi_rready = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("abort_rvalid", bus.s_axi_rvalid, 1'b0);
            chk("abort_arready", bus.s_axi_arready, 1'b1);
            return;
         end
         if (mode == 0) rr = 1'b1;
         else if (mode == 2) rr = !(i == 1 && stall < 5);
         else rr = 1'($urandom_range(0, 1));
         if (mode == 2 && !rr) stall++;
         bus.s_axi_rready = rr;
         @(negedge clk);
         cyc++;
         if (rr) i++;
      end
      bus.s_axi_rready = 1'b0;
      chk("beats_done", i, int'(len) + 1);
      if (mode == 0) chk("throughput_cycles", cyc, int'(len) + 1);
      if (mode == 2) chk("stall_cycles", cyc, int'(len) + 6);
      chk("rvalid_after_last", bus.s_axi_rvalid, 1'b0);
      chk("arready_after_last", bus.s_axi_arready, 1'b1);
      chk("mem_access", saw_req, legal);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int off, sz, len, sizei;
      bus.s_axi_arid    = '0;
      bus.s_axi_araddr  = '0;
      bus.s_axi_arlen   = '0;
      bus.s_axi_arsize  = '0;
      bus.s_axi_arburst = '0;
      bus.s_axi_arvalid = 1'b0;
      bus.s_axi_rready  = 1'b0;
      bus.mem_req_rdy   = 1'b0;
      bus.mem_resp_val  = 1'b0;
      bus.mem_resp_data = '0;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_arready", bus.s_axi_arready, 1'b1);
      chk("rst_rvalid", bus.s_axi_rvalid, 1'b0);
      chk("rst_rlast", bus.s_axi_rlast, 1'b0);
      chk("rst_rresp", bus.s_axi_rresp, 2'b00);
      chk("rst_rid", bus.s_axi_rid, 0);
      chk("rst_rdata", bus.s_axi_rdata, 0);
      chk("rst_mem_req_val", bus.mem_req_val, 1'b0);
      chk("rst_mem_req_addr", bus.mem_req_addr, 0);
      chk("rst_mem_resp_rdy", bus.mem_resp_rdy, 1'b1);
      rst = 1'b0;
      @(negedge clk);

      do_read(6'h01, 64'h2000, 8'd7, 3'd3, 2'b01, 0, -1);
      do_read(6'h02, 64'h2014, 8'd0, 3'd2, 2'b01, 0, -1);
      do_read(6'h03, 64'h2038, 8'd1, 3'd3, 2'b01, 0, -1);
      do_read(6'h04, 64'h2000, 8'd1, 3'd3, 2'b10, 0, -1);
      do_read(6'h05, 64'h2000, 8'd3, 3'd3, 2'b01, 2, -1);
      do_read(6'h08, 64'h4000, 8'd0, 3'd4, 2'b01, 0, -1);
      do_read(6'h09, 64'h5000, 8'd63, 3'd0, 2'b01, 1, -1);
      do_read(6'h0a, 64'h5000, 8'd255, 3'd0, 2'b01, 0, -1);

      do_read(6'h06, 64'h2000, 8'd3, 3'd3, 2'b01, 0, 2);
      @(negedge clk);
      bus.mem_resp_val  = 1'b1;
      bus.mem_resp_data = {16{32'hdeadbeef}};
      chk("stale_resp_rdy", bus.mem_resp_rdy, 1'b1);
      @(negedge clk);
      bus.mem_resp_val = 1'b0;
      chk("stale_resp_rvalid", bus.s_axi_rvalid, 1'b0);
      chk("stale_resp_arready", bus.s_axi_arready, 1'b1);
      do_read(6'h07, 64'h3000, 8'd7, 3'd3, 2'b01, 0, -1);

      for (int t = 0; t < 40; t++) begin
         sizei = $urandom_range(0, 4);
         sz    = 1 << sizei;
         off   = $urandom_range(0, 63);
         if ($urandom_range(0, 3) != 0) off = off & ~(sz - 1);
         if ($urandom_range(0, 3) != 0 && off + sz <= 64) len = $urandom_range(0, (64 - off) / sz - 1);
         else len = $urandom_range(0, 15);
         do_read(6'($urandom), {42'($urandom), 16'($urandom_range(0, 1023)), 6'(off)}, 8'(len),
                 3'(sizei), ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 2)) : 2'b01,
                 $urandom_range(0, 1), -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/noc_axi4_bridge_read_resp.md
NOC_AXI4_BRIDGE_READ_RESP -- requirements
Module: noc_axi4_bridge_read_resp

Interface
REQ-001 Parameter AXI4_DAT_WIDTH_USED, default `AXI4_DATA_WIDTH (512); R-channel data width; power of two, 8..`AXI4_DATA_WIDTH.
REQ-002 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  reset; synchronous, active-high.
REQ-004 Ports s_axi_arid/araddr/arlen/arsize/arburst/arvalid  input  `AXI4_ID/ADDR/LEN/SIZE/BURST_WIDTH,1  AXI4 read address channel; remaining AR fields are accepted and ignored.
REQ-005 Port s_axi_arready  output  1  AR accept.
REQ-006 Ports s_axi_rid/rdata/rresp/rlast/ruser/rvalid  output  `AXI4_ID_WIDTH/AXI4_DAT_WIDTH_USED/`AXI4_RESP_WIDTH/1/`AXI4_USER_WIDTH/1  AXI4 read data channel.
REQ-007 Port s_axi_rready  input  1  R accept.
REQ-008 Ports mem_req_val  output  1; mem_req_addr  output  `AXI4_ADDR_WIDTH; mem_req_rdy  input  1  line-read request to backing store.
REQ-009 Ports mem_resp_val  input  1; mem_resp_data  input  `AXI4_DATA_WIDTH; mem_resp_rdy  output  1  line-read response.

Function
REQ-010 FSM states SHALL be IDLE, MEM_REQ, MEM_WAIT, SEND, ERR_SEND; one transaction in flight.
REQ-011 s_axi_arready SHALL be 1 only in IDLE; on arvalid&arready, arid/araddr/arlen/arsize are registered and beat counter cleared.
REQ-012 Request is legal iff arburst==INCR, (1<<arsize) <= AXI4_DAT_WIDTH_USED/8, and [araddr, araddr+(arlen+1)*(1<<arsize)-1] lies inside one 64-byte line.
REQ-013 Legal: IDLE->MEM_REQ; illegal: IDLE->ERR_SEND with no memory access.
REQ-014 MEM_REQ: mem_req_val=1, mem_req_addr=araddr with bits [5:0] zeroed; on mem_req_rdy -> MEM_WAIT.
REQ-015 mem_resp_rdy SHALL be 1 in MEM_WAIT and IDLE (stale responses in IDLE are dropped); MEM_WAIT captures mem_resp_data on mem_resp_val -> SEND.
REQ-016 Beat i byte address = araddr + i*(1<<arsize); s_axi_rdata = line slice of AXI4_DAT_WIDTH_USED bits containing that address (address aligned down to AXI4_DAT_WIDTH_USED/8), full slice driven, narrow lanes per AXI4.
REQ-017 SEND/ERR_SEND: rvalid=1, rid=registered arid, rlast=1 iff beat counter==arlen, ruser=0.
REQ-018 rresp SHALL be 2'b00 in SEND; in ERR_SEND rresp=2'b10 (SLVERR), rdata=0, arlen+1 beats still issued.
REQ-019 Counter increments on rvalid&rready; beat with rlast accepted -> IDLE; next AR acceptable the following cycle.
REQ-020 While rvalid=1 and rready=0, all R outputs SHALL hold stable.
REQ-021 Latency: AR accept to MEM_REQ 1 cycle; mem response capture to first rvalid 1 cycle; 1 beat/cycle under continuous rready.
REQ-022 Address arithmetic SHALL be `AXI4_ADDR_WIDTH wide; beat counter `AXI4_LEN_WIDTH wide; arlen=255 legal only if within-line rule holds.

Reset
REQ-023 With rst=1 at a clock edge: state IDLE, counter 0, registered fields 0, line buffer 0.
REQ-024 Reset outputs: arready=1 after release, rvalid=0, rlast=0, rresp=0, rid=0, rdata=0, mem_req_val=0, mem_req_addr=0, mem_resp_rdy=1.
REQ-025 Reset mid-transaction SHALL abort it; no further beats for it; a mem response arriving after reset is drained in IDLE.

Verification
REQ-026 W=512, AR addr 0x1000 len 0 size 6 id 0x5, mem line L -> mem_req_addr 0x1000, one beat rdata=L, rlast=1, rresp=0, rid=0x5.
REQ-027 W=64, addr 0x2000 len 7 size 3 -> 8 beats, beat i = L[64i+:64], rlast only on beat 7.
REQ-028 W=64, addr 0x2014 len 0 size 2 -> mem_req_addr 0x2000, one beat rdata=L[128+:64], rlast=1.
REQ-029 addr 0x2038 len 1 size 3 (crosses line), and separately arburst=WRAP -> 2 resp. arlen+1 beats rresp=2'b10, rdata=0, mem_req_val never 1.
REQ-030 W=64 len 3, rready low 5 cycles at beat 1 -> rvalid, rdata, rlast stable; sequence completes 4 beats in order.
REQ-031 rst pulsed during SEND beat 2 -> next cycle rvalid=0, arready=1; following read of 0x3000 returns correct data.
